// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready/data handshake bundle for one pipeline boundary.
//   valid  : producer offers data
//   ready  : consumer can accept data
//   data   : payload, DATA_W bits
// Modports:
//   master : producer side (drives valid/data, samples ready)
//   slave  : consumer side (samples valid/data, drives ready)
interface pipe_skid_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: CPU pipeline boundary register with a 2-entry skid buffer.
// Upstream ready is a pure register output (no path from downstream ready),
// a synchronous flush replaces all held entries with a bubble, and a
// saturating counter tallies cycles where the output is stalled.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   flush      : synchronous kill of all held entries
//   up         : upstream handshake (in_valid / in_data / in_ready)
//   dn         : downstream handshake (out_valid / out_data / out_ready)
//   occupancy  : number of held entries (0..2)
//   stall_cnt  : saturating count of out_valid & !out_ready cycles
module pipe_skid_reg #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_skid_reg_if.slave       up,
    pipe_skid_reg_if.master      dn,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    // State encoding is {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ILLEGAL = 2'b01,
        BUSY    = 2'b10,
        FULL    = 2'b11
    } state_t;

    state_t            state_p1;
    state_t            state_nx;
    logic [DATA_W-1:0] main_data_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              main_vld_p1;
    logic              skid_vld_p1;
    logic              in_fire;
    logic              out_fire;
    logic              load_main;
    logic              main_from_skid;
    logic              load_skid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign main_vld_p1 = state_p1[1];
    assign skid_vld_p1 = state_p1[0];

    assign up.ready  = ~skid_vld_p1;
    assign dn.valid  = main_vld_p1;
    assign dn.data   = main_data_p1;
    assign occupancy = {1'b0, main_vld_p1} + {1'b0, skid_vld_p1};

    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;

    always_comb begin
        state_nx       = state_p1;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_nx  = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nx  = FULL;
                end else if (out_fire) begin
                    // Main data is left as-is; out_valid alone marks it stale.
                    state_nx  = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nx       = BUSY;
                end
            end
            default: begin
                // Unreachable skid-only state recovers to EMPTY.
                state_nx = EMPTY;
            end
        endcase
    end

    // ---- stage p0 -> p1: control and payload registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p1 <= EMPTY;
        end else if (flush) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data_p1 <= BUBBLE_VAL;
            skid_data_p1 <= BUBBLE_VAL;
        end else if (flush) begin
            main_data_p1 <= BUBBLE_VAL;
            skid_data_p1 <= BUBBLE_VAL;
        end else begin
            if (load_main) begin
                main_data_p1 <= main_from_skid ? skid_data_p1 : up.data;
            end
            if (load_skid) begin
                skid_data_p1 <= up.data;
            end
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (dn.valid && !dn.ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed 32-bit instruction/PC register that uses a global stall. Each boundary gets a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is a pure register output and never a combinational function of downstream ready. A synchronous flush injects a configurable bubble, and a saturating stall counter supports performance analysis.

Parameters:
DATA_W, 64, payload width in bits (e.g. {PC, instruction} for IF/ID).
BUBBLE_VAL, {DATA_W{1'b0}}, payload loaded on reset and flush (NOP encoding).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all held entries; highest priority after reset.
in_valid  input  1  upstream offers in_data.
in_data  input  DATA_W  upstream payload.
in_ready  output  1  stage can accept; registered, equals !skid_valid.
out_valid  output  1  out_data holds a valid entry.
out_data  output  DATA_W  payload of the main entry; registered.
out_ready  input  1  downstream accepts out_data.
occupancy  output  2  number of held entries: 0, 1 or 2.
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=BUBBLE_VAL, skid data=BUBBLE_VAL.
  - in_ready=1, occupancy=0, stall_cnt=0.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine, encoded by {main_valid, skid_valid}:
  - EMPTY (00):
    - in_fire: main<=in_data, go to BUSY.
    - Otherwise hold. out_data keeps its last value.
  - BUSY (10):
    - in_fire & out_fire: main<=in_data, stay BUSY.
    - in_fire & !out_fire: skid<=in_data, go to FULL.
    - !in_fire & out_fire: go to EMPTY; main data is not rewritten.
    - Neither: hold.
  - FULL (11): in_ready=0.
    - out_fire: main<=skid, skid_valid<=0, go to BUSY.
    - Otherwise hold.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge N appears on out_data after edge N.
  - Sustained throughput is 1 transfer per cycle when out_ready=1.
- Ordering is strict FIFO. Data is never duplicated or dropped, except by flush.
- Flush (synchronous, at the clock edge):
  - main_valid<=0, skid_valid<=0; main and skid data <= BUBBLE_VAL; state becomes EMPTY.
  - An in_fire in the same cycle is discarded. The upstream handshake still completes, so upstream must treat its flushed instruction as killed.
  - An out_fire in the same cycle completes normally for downstream. The output register is still cleared.
- in_ready depends only on state; there is no combinational path from out_ready or flush to in_ready.
- occupancy = main_valid + skid_valid.
- stall_cnt:
  - Increments on every edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset only, not by flush.
- Illegal state 01 is unreachable. If encountered, it is treated as EMPTY on the next edge.

Test Plan:
- Reset then stream 0x11, 0x22, 0x33 with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance; in_ready stays 1; occupancy=1.
- Send 0xA, then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA. Raise out_ready -> 0xA then 0xB emerge in order; in_ready returns to 1 after the first drain.
- FULL state, assert flush with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1; 0xC never appears.
- Hold out_valid=1 with out_ready=0 for 5 cycles, then flush -> stall_cnt=5 and it stays 5 after the flush. With CNT_W=3 and a 10-cycle stall -> stall_cnt saturates at 7.
- Assert reset asynchronously between clock edges while FULL -> out_valid, occupancy and in_ready change immediately, with no clock edge, to 0, 0 and 1.
- Random in_valid/out_ready (10k cycles), DATA_W=64, with a scoreboard -> output sequence equals input sequence; there is never an in_fire while occupancy=2.
